// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and state encoding
// Purpose: the frame constants and FSM state encoding used by uart_tx and uart_rx.
// Ports: none (package).
package uart_pkg;

    localparam int DATA_W     = 8;
    localparam int FRAME_BITS = 10;

    // The receiver decodes the same 2-bit encoding, so the values are pinned.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_DATA  = 2'b10,
        ST_STOP  = 2'b11
    } uart_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - per-bit baud counter with last-cycle tick
// Purpose: counts 0..clk_per_bit-1 and flags the final cycle of each serial bit.
// Ports:
//   clk   in  system clock
//   rst   in  synchronous active-high reset
//   clear in  hold the counter at 0 (line idle)
//   tick  out high during the last cycle of a bit period
module uart_baud_tick #(
    parameter int clk_per_bit = 217
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (clk_per_bit > 1) ? $clog2(clk_per_bit) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(clk_per_bit - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        tick  = !clear && (cnt_q == LAST);
        cnt_d = cnt_q + CNT_W'(1);
        // Wrap at the bit boundary so the next bit starts from 0.
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with one-entry holding register
// Purpose: serialises bytes as start + 8 data bits (LSB first) + stop, gapless
//          back-to-back when a byte is waiting in the holding register.
// Ports:
//   clk       in  system clock
//   rst       in  synchronous active-high reset
//   tx_data   in  byte to send, sampled on the accept edge
//   tx_valid  in  upstream offers tx_data
//   tx_ready  out holding register empty, byte can be accepted
//   serialOut out registered UART line, idle high
//   tx_busy   out a frame is in progress
//   tx_done   out one-cycle pulse after a stop bit completes
module uart_tx
    import uart_pkg::*;
#(
    parameter int clk_per_bit = 217
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              serialOut,
    output logic              tx_busy,
    output logic              tx_done
);

    uart_state_e       state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic [2:0]        idx_q, idx_d;
    logic              serial_q, serial_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic tick;
    logic accept;
    logic load_direct;

    uart_baud_tick #(
        .clk_per_bit(clk_per_bit)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(state_q == ST_IDLE),
        .tick (tick)
    );

    always_comb begin
        // tx_ready depends only on the hold register, never on tx_valid.
        accept      = tx_valid && !hold_full_q;
        load_direct = 1'b0;
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        idx_d       = idx_q;

        case (state_q)
            ST_IDLE: begin
                idx_d = 3'd0;
                if (accept) begin
                    load_direct = 1'b1;
                    shift_d     = tx_data;
                    state_d     = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                    idx_d   = 3'd0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 3'd1;   // 7 wraps to 0 on the way into STOP
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                        state_d     = ST_START;
                    end else if (accept) begin
                        load_direct = 1'b1;
                        shift_d     = tx_data;
                        state_d     = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Anything accepted that the shifter cannot take right now is parked.
        if (accept && !load_direct) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        // Outputs are computed from the next state so they line up with it.
        case (state_d)
            ST_START: serial_d = 1'b0;
            ST_DATA:  serial_d = shift_d[0];
            default:  serial_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_q == ST_STOP) && tick;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            idx_q       <= 3'd0;
            serial_q    <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            idx_q       <= idx_d;
            serial_q    <= serial_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign tx_ready  = !hold_full_q;
    assign serialOut = serial_q;
    assign tx_busy   = busy_q;
    assign tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx
// Purpose: drives directed byte sequences at clk_per_bit=4 and compares the
//          line, handshake and status outputs with hand-derived waveforms.
// Ports: none (top-level bench).
module tb_uart_tx;

    logic       clk;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       serialOut;
    logic       tx_busy;
    logic       tx_done;

    int errors = 0;
    int checks = 0;

    uart_tx #(
        .clk_per_bit(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .serialOut(serialOut),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Level of frame bit j (0 = start, 1..8 = data LSB first, 9 = stop).
    function automatic logic frame_bit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return b[j-1];
    endfunction

    // Sends n bytes. Byte 0 is offered just before edge N (k counts negedges
    // after edge N). Byte i>0 is offered from cycle o1/o2 and held until the
    // handshake completes. Expected: gapless frames starting at k=0,40,80;
    // tx_ready low inside the given windows.
    task automatic run_frames(input string tag, input int n,
                              input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input int o1, input int o2,
                              input int rlo1, input int rhi1, input int rlo2, input int rhi2);
        logic [7:0] bs [3];
        int   idx;
        int   nacc;
        int   start_k;
        logic offer;
        logic exp_line;
        logic exp_ready;
        bs[0] = b0;
        bs[1] = b1;
        bs[2] = b2;
        idx   = 0;
        nacc  = 0;
        @(negedge clk);
        tx_data  = bs[0];
        tx_valid = 1'b1;
        offer    = tx_ready;
        for (int k = 0; k < 40 * n + 3; k++) begin
            @(negedge clk);
            if (offer) begin
                nacc++;
                idx++;
            end
            exp_line  = (k / 40 < n) ? frame_bit(bs[k / 40], (k % 40) / 4) : 1'b1;
            exp_ready = !((k >= rlo1 && k <= rhi1) || (k >= rlo2 && k <= rhi2));
            check($sformatf("%s_line_k%0d", tag, k), 32'(serialOut), 32'(exp_line));
            check($sformatf("%s_done_k%0d", tag, k), 32'(tx_done),
                  32'(k > 0 && k % 40 == 0 && k / 40 <= n));
            check($sformatf("%s_busy_k%0d", tag, k), 32'(tx_busy), 32'(k < 40 * n));
            check($sformatf("%s_ready_k%0d", tag, k), 32'(tx_ready), 32'(exp_ready));
            start_k = (idx == 1) ? o1 : o2;
            if (idx < n && k >= start_k) begin
                tx_data  = bs[idx];
                tx_valid = 1'b1;
            end else begin
                tx_valid = 1'b0;
            end
            offer = tx_valid && tx_ready;
        end
        tx_valid = 1'b0;
        check($sformatf("%s_accepts", tag), 32'(nacc), 32'(n));
    endtask

    initial begin
        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (2) @(negedge clk);
        check("reset_state", {28'd0, serialOut, tx_ready, tx_busy, tx_done}, 32'b1100);
        rst = 1'b0;

        // Idle: line high, ready, not busy, no done.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("idle_%0d", i), {28'd0, serialOut, tx_ready, tx_busy, tx_done}, 32'b1100);
        end

        // Single frame from IDLE.
        run_frames("a5", 1, 8'hA5, 8'h00, 8'h00, 0, 0, 1000, 0, 1000, 0);

        // Second byte offered during the first frame's DATA: held, gapless.
        run_frames("00ff", 2, 8'h00, 8'hFF, 8'h00, 10, 0, 11, 39, 1000, 0);

        // tx_valid held continuously across three bytes.
        run_frames("stream", 3, 8'h3C, 8'hC3, 8'h55, 0, 0, 1, 39, 41, 79);

        // New byte offered exactly on the final STOP cycle with hold empty.
        run_frames("laststop", 2, 8'h5A, 8'h96, 8'h00, 39, 0, 1000, 0, 1000, 0);

        // Reset in the middle of data bit 3 of 0x81 with 0x99 held.
        @(negedge clk);
        tx_data  = 8'h81;
        tx_valid = 1'b1;
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            if (k == 2) begin
                tx_data  = 8'h99;
                tx_valid = 1'b1;
            end else begin
                tx_valid = 1'b0;
            end
            if (k == 3) check("rst_held_ready", 32'(tx_ready), 32'd0);
            if (k == 16) check("rst_bit3_line", 32'(serialOut), 32'd0);
            if (k == 17) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        check("rst_after", {28'd0, serialOut, tx_ready, tx_busy, tx_done}, 32'b1100);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            check($sformatf("rst_quiet_%0d", i), {28'd0, serialOut, tx_ready, tx_busy, tx_done}, 32'b1100);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
